// File: rtl/counter_pkg.sv
// Shared constants for the counter block: default width and terminal count.
package counter_pkg;

   localparam int COUNTER_WIDTH_DEF = 8;
   localparam int COUNTER_MAX_DEF   = 255;

endpackage : counter_pkg

// File: rtl/counter.sv
// Up-counter with programmable terminal count, asynchronous active-high
// reset, and a registered one-cycle wrap pulse. Both outputs come straight
// from flip-flops, so enable never reaches an output combinationally.
module counter
   import counter_pkg::*;
#(
   parameter int WIDTH     = COUNTER_WIDTH_DEF,
   parameter int MAX_COUNT = COUNTER_MAX_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   // Largest value a WIDTH-bit count can hold, computed wide enough that it
   // cannot overflow for any sensible WIDTH.
   localparam longint COUNT_LIMIT = (longint'(1) << WIDTH) - longint'(1);

   // An illegal parameter set stops elaboration instead of building a
   // counter that silently truncates its terminal value.
   if (WIDTH < 1) begin : g_bad_width
      $fatal(1, "counter: WIDTH must be >= 1");
   end
   if (MAX_COUNT < 1 || longint'(MAX_COUNT) > COUNT_LIMIT) begin : g_bad_max
      $fatal(1, "counter: MAX_COUNT must lie in 1 .. 2**WIDTH-1");
   end

   localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(MAX_COUNT);

   logic             at_terminal;
   logic [WIDTH-1:0] count_next;
   logic             wrap_next;

   // Next-state logic: step or wrap the count when enabled, flag the wrap.
   always_comb begin
      // NOTE: every output of this block gets a value before any branch, so a
      // path that skips an assignment cannot infer a latch.
      count_next  = count;
      wrap_next   = 1'b0;
      at_terminal = (count == TERMINAL);
      if (enable) begin
         count_next = at_terminal ? '0 : count + 1'b1;
         wrap_next  = at_terminal;
      end
   end

   // State registers; reset clears both immediately, without waiting for clk.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      if (reset) begin
         count <= '0;
         wrap  <= 1'b0;
      end else begin
         count <= count_next;
         wrap  <= wrap_next;
      end
   end

endmodule : counter

// File: tb/tb_counter.sv
// Self-checking bench for counter: a default-parameter instance and a small
// WIDTH=3 / MAX_COUNT=5 instance, compared every cycle against a model that
// counts enabled edges and reduces them modulo (MAX_COUNT+1).
module tb_counter;

   localparam int MAX_D = 255;
   localparam int MAX_S = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en_d = 1'b0;
   logic       en_s = 1'b0;
   logic [7:0] count_d;
   logic       wrap_d;
   logic [2:0] count_s;
   logic       wrap_s;

   int checks = 0;
   int failures = 0;

   // Model state: enabled edges since reset, and expected wrap flags.
   int ev_d = 0;
   int ev_s = 0;
   bit xw_d = 1'b0;
   bit xw_s = 1'b0;
   int wraps_seen;

   int exp_seq_s [7] = '{1, 2, 3, 4, 5, 0, 1};
   bit exp_wrp_s [7] = '{0, 0, 0, 0, 0, 1, 0};

   counter dut_d (
      .clk    (clk),
      .reset  (reset),
      .enable (en_d),
      .count  (count_d),
      .wrap   (wrap_d)
   );

   counter #(.WIDTH(3), .MAX_COUNT(MAX_S)) dut_s (
      .clk    (clk),
      .reset  (reset),
      .enable (en_s),
      .count  (count_s),
      .wrap   (wrap_s)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("count_d", 32'(count_d), 32'(ev_d % (MAX_D + 1)));
      check("wrap_d",  32'(wrap_d),  32'(xw_d));
      check("count_s", 32'(count_s), 32'(ev_s % (MAX_S + 1)));
      check("wrap_s",  32'(wrap_s),  32'(xw_s));
   endtask

   // One clock cycle: drive inputs between edges, update the model at the
   // rising edge, sample 1 ns later. A reset request is checked for its
   // asynchronous effect before the edge arrives.
   task automatic step(input bit r, input bit ea, input bit eb);
      @(negedge clk);
      reset = r;
      en_d  = ea;
      en_s  = eb;
      if (r) begin
         #1;
         ev_d = 0; ev_s = 0; xw_d = 1'b0; xw_s = 1'b0;
         check("async_rst_count_d", 32'(count_d), 32'd0);
         check("async_rst_wrap_d",  32'(wrap_d),  32'd0);
         check("async_rst_count_s", 32'(count_s), 32'd0);
      end
      @(posedge clk);
      if (!r) begin
         xw_d = ea && ((ev_d % (MAX_D + 1)) == MAX_D);
         xw_s = eb && ((ev_s % (MAX_S + 1)) == MAX_S);
         if (ea) ev_d++;
         if (eb) ev_s++;
      end
      #1;
      check_all();
   endtask

   initial begin
      // Reset held for 20 ns with enable low.
      #1;
      check("por_count_d", 32'(count_d), 32'd0);
      check("por_wrap_d",  32'(wrap_d),  32'd0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);

      // Twenty enabled edges: default counter climbs to 0x14.
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
      check("run20_count_d", 32'(count_d), 32'h14);

      // Hold for five edges, then ten more enabled edges.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
      check("hold_count_d", 32'(count_d), 32'h14);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
      check("resume_count_d", 32'(count_d), 32'h1E);

      // Reset mid-count (enable high throughout), then five enabled edges.
      step(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
      check("post_rst_count_d", 32'(count_d), 32'h05);

      // Small counter: 0..5 then back to 0 with a single wrap pulse.
      step(1'b1, 1'b0, 1'b0);
      check("small_start", 32'(count_s), 32'd0);
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b0, 1'b1);
         check("small_seq",  32'(count_s), 32'(exp_seq_s[i]));
         check("small_wrap", 32'(wrap_s),  32'(exp_wrp_s[i]));
      end

      // Default counter: 256 enabled edges from 0 return to 0 with one wrap.
      step(1'b1, 1'b0, 1'b0);
      wraps_seen = 0;
      for (int i = 0; i < 256; i++) begin
         step(1'b0, 1'b1, 1'b0);
         wraps_seen += int'(wrap_d);
      end
      check("full_lap_count_d", 32'(count_d), 32'h00);
      check("full_lap_wraps",   32'(wraps_seen), 32'd1);
      step(1'b0, 1'b0, 1'b0);
      check("wrap_clears", 32'(wrap_d), 32'd0);

      // Randomized enables with occasional resets.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 59) == 0,
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) != 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_counter

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter WIDTH, default 8: bit width of count.
REQ-002 Parameter MAX_COUNT, default 255: terminal count value; count wraps to 0 after it.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock, all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  count-enable, sampled on the rising clk edge.
REQ-007 count  output  WIDTH  current count value, driven directly from a register.
REQ-008 wrap  output  1  registered one-cycle pulse, high in the cycle after count went MAX_COUNT->0.

Function
REQ-009 On a rising clk edge with reset low and enable high: count SHALL become count+1 if count != MAX_COUNT, else 0.
REQ-010 On a rising clk edge with reset low and enable low: count SHALL hold its value; wrap SHALL be 0.
REQ-011 Latency: count SHALL reflect each increment one clock edge after enable is sampled high; there is no pipeline delay.
REQ-012 wrap SHALL be 1 only for the clock cycle immediately following an enabled edge at which count equalled MAX_COUNT; otherwise 0.
REQ-013 Increment arithmetic SHALL be WIDTH bits unsigned; count SHALL never exceed MAX_COUNT once reset has been applied.
REQ-014 If MAX_COUNT == 2^WIDTH-1, the wrap SHALL coincide with natural overflow and give the same result.
REQ-015 Legal parameters: WIDTH >= 1, 1 <= MAX_COUNT <= 2^WIDTH-1; elaboration SHALL fail with a fatal message otherwise.
REQ-016 enable toggling mid-run SHALL neither lose nor duplicate counts; counting resumes from the held value.

Reset
REQ-017 reset high SHALL immediately (asynchronously, with no clock edge) force count to 0 and wrap to 0.
REQ-018 While reset is high, count SHALL stay 0 regardless of enable and clk.
REQ-019 Reset SHALL dominate enable; after reset deasserts, the first enabled rising edge SHALL produce count = 1.
REQ-020 Reset asserted mid-count SHALL discard the count; no state survives reset.

Structure
REQ-021 Package counter_pkg SHALL hold the default constants COUNTER_WIDTH_DEF=8 and COUNTER_MAX_DEF=255; module parameter defaults SHALL come from it.
REQ-022 Single flat module; no sub-module is required; terminal-count compare and next-value logic are inline combinational logic.
REQ-023 Exactly WIDTH+1 flip-flops (count, wrap); no latches; no combinational path from enable to outputs.

Verification (clk period 10 ns, defaults unless stated)
REQ-024 reset=1 for 20 ns, enable=0 -> count=0x00 throughout, wrap=0.
REQ-025 Release reset, enable=1 for 200 ns (20 edges) -> count steps 0x01..0x14, ends at 0x14.
REQ-026 enable=0 for 50 ns, then enable=1 for 100 ns -> count holds 0x14, then reaches 0x1E.
REQ-027 reset=1 for 10 ns while counting at 0x1E, asserted between edges -> count=0x00 before the next clk edge; after release, 50 ns enabled -> count=0x05.
REQ-028 MAX_COUNT=5, WIDTH=3, enable=1 -> count 0,1,2,3,4,5,0,1; wrap=1 only in the cycle count shows 0 after 5.
REQ-029 Defaults, 256 enabled edges from 0 -> count returns to 0x00 with a single wrap pulse.
